// File: rtl/muldiv_params.sv
// Shared types for the multiply/divide front end: data widths, operation codes and FSM states.
package muldiv_params;

  localparam int CPU_DATA_WIDTH = 32;
  localparam int MUL_CNT_WIDTH  = 3;

  typedef logic [CPU_DATA_WIDTH-1:0]   cpu_data_t;
  typedef logic [2*CPU_DATA_WIDTH-1:0] multiply_result_bus_t;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_hilo_unit.sv
// Execute-stage front end for the external multiplier/divider: launches operations,
// owns the architectural HI/LO registers and stalls the pipeline while a result is pending.
module muldiv_hilo_unit
  import muldiv_params::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  input  muldiv_op_t           req_op,
  input  cpu_data_t            src_a,
  input  cpu_data_t            src_b,
  input  logic                 flush,
  output logic                 busy,
  output cpu_data_t            hi_value,
  output cpu_data_t            lo_value,
  output logic                 mul_valid,
  output logic                 mul_signed,
  output cpu_data_t            mul_a,
  output cpu_data_t            mul_b,
  input  multiply_result_bus_t mul_result,
  output logic                 div_start,
  output logic                 div_cancel,
  output logic                 div_signed,
  output cpu_data_t            div_dividend,
  output cpu_data_t            div_divisor,
  input  logic                 div_done,
  input  cpu_data_t            div_quotient,
  input  cpu_data_t            div_remainder
);

  muldiv_state_t            r_state, w_next_state;
  logic [MUL_CNT_WIDTH-1:0] r_count;
  logic                     r_launch, r_signed;
  cpu_data_t                r_op_a, r_op_b, r_hi, r_lo;

  logic      w_accept, w_launch, w_load_count, w_signed;
  logic      w_hi_we, w_lo_we, w_div_cancel;
  cpu_data_t w_hi_d, w_lo_d;

  assign w_accept = req_valid && (r_state == IDLE) && !flush;
  assign w_signed = (req_op == MULT) || (req_op == DIV);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_load_count = 1'b0;
    w_hi_we      = 1'b0;
    w_lo_we      = 1'b0;
    w_hi_d       = '0;
    w_lo_d       = '0;
    w_div_cancel = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (req_op)
            MULT, MULTU: begin
              w_next_state = MUL_WAIT;
              w_launch     = 1'b1;
              w_load_count = 1'b1;
            end
            DIV, DIVU: begin
              w_next_state = DIV_WAIT;
              w_launch     = 1'b1;
            end
            MTHI: begin
              w_hi_we = 1'b1;
              w_hi_d  = src_a;
            end
            MTLO: begin
              w_lo_we = 1'b1;
              w_lo_d  = src_a;
            end
            default: ;
          endcase
        end
      end
      MUL_WAIT: begin
        // Flush beats a product arriving in the same cycle.
        if (flush) begin
          w_next_state = IDLE;
        end else if (r_count == '0) begin
          w_hi_we      = 1'b1;
          w_lo_we      = 1'b1;
          w_hi_d       = mul_result[2*CPU_DATA_WIDTH-1:CPU_DATA_WIDTH];
          w_lo_d       = mul_result[CPU_DATA_WIDTH-1:0];
          w_next_state = IDLE;
        end
      end
      DIV_WAIT: begin
        if (flush) begin
          w_div_cancel = 1'b1;
          w_next_state = IDLE;
        end else if (div_done) begin
          w_hi_we      = 1'b1;
          w_lo_we      = 1'b1;
          w_hi_d       = div_remainder;
          w_lo_d       = div_quotient;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_launch <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_launch <= w_launch;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_load_count) begin
      r_count <= MUL_CNT_WIDTH'(MUL_LATENCY);
    end else if ((r_state == MUL_WAIT) && (r_count != '0)) begin
      r_count <= r_count - MUL_CNT_WIDTH'(1);
    end
  end

  // Operands are shared by both units and held steady for the whole wait.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_signed <= 1'b0;
    end else if (w_launch) begin
      r_op_a   <= src_a;
      r_op_b   <= src_b;
      r_signed <= w_signed;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_d;
      if (w_lo_we) r_lo <= w_lo_d;
    end
  end

  assign busy         = (r_state != IDLE);
  assign hi_value     = r_hi;
  assign lo_value     = r_lo;
  assign mul_valid    = r_launch && (r_state == MUL_WAIT);
  assign mul_signed   = r_signed;
  assign mul_a        = r_op_a;
  assign mul_b        = r_op_b;
  assign div_start    = r_launch && (r_state == DIV_WAIT);
  assign div_cancel   = w_div_cancel;
  assign div_signed   = r_signed;
  assign div_dividend = r_op_a;
  assign div_divisor  = r_op_b;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit with behavioural multiplier/divider models
// and a HI/LO scoreboard.
module tb_muldiv_hilo_unit;
  import muldiv_params::*;

  localparam int MUL_L    = 2;
  localparam int DIV_CYC  = 33;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 req_valid;
  muldiv_op_t           req_op;
  cpu_data_t            src_a, src_b;
  logic                 flush;
  logic                 busy;
  cpu_data_t            hi_value, lo_value;
  logic                 mul_valid, mul_signed;
  cpu_data_t            mul_a, mul_b;
  multiply_result_bus_t mul_result = '0;
  logic                 div_start, div_cancel, div_signed;
  cpu_data_t            div_dividend, div_divisor;
  logic                 div_done = 1'b0;
  cpu_data_t            div_quotient = '0, div_remainder = '0;

  int    n_tests = 0;
  int    n_fail  = 0;
  hilo_t sb_q[$];
  hilo_t exp_v;
  logic [31:0] m_hi = '0, m_lo = '0;
  int    stray_req = 0;

  muldiv_hilo_unit #(.MUL_LATENCY(MUL_L)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy),
    .hi_value(hi_value), .lo_value(lo_value), .mul_valid(mul_valid),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .div_start(div_start), .div_cancel(div_cancel), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clock = ~clock;

  // ---------------- external unit models ----------------
  function automatic logic [63:0] mul_model(logic sgn, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (sgn) return sa * sb;
    return {32'b0, a} * {32'b0, b};
  endfunction

  logic [63:0] mpipe [MUL_L];
  logic        cap_mv, cap_ms, cap_ds, cap_dc, cap_dsg;
  logic [31:0] cap_ma, cap_mb, cap_dd, cap_dv, dm_a, dm_b;
  logic        dm_sgn, dm_active = 1'b0;
  int          dm_cnt = 0, stray_ack = 0;
  logic signed [31:0] sda, sdb;

  initial for (int k = 0; k < MUL_L; k++) mpipe[k] = '0;

  // Models sample pre-edge DUT outputs, then update their outputs for the next cycle.
  always @(posedge clock) begin
    cap_mv = mul_valid;  cap_ms = mul_signed; cap_ma = mul_a; cap_mb = mul_b;
    cap_ds = div_start;  cap_dc = div_cancel; cap_dsg = div_signed;
    cap_dd = div_dividend; cap_dv = div_divisor;
    #1;
    for (int k = MUL_L - 1; k > 0; k--) mpipe[k] = mpipe[k-1];
    mpipe[0]   = cap_mv ? mul_model(cap_ms, cap_ma, cap_mb) : 64'h0;
    mul_result = mpipe[MUL_L-1];

    div_done = 1'b0;
    if (cap_dc) begin
      dm_active = 1'b0;
    end else if (cap_ds) begin
      dm_active = 1'b1; dm_cnt = 1; dm_a = cap_dd; dm_b = cap_dv; dm_sgn = cap_dsg;
    end else if (dm_active) begin
      dm_cnt++;
    end
    if (dm_active && dm_cnt == DIV_CYC) begin
      dm_active = 1'b0;
      div_done  = 1'b1;
      if (dm_b == 0) begin
        div_quotient = '1; div_remainder = dm_a;
      end else if (dm_sgn) begin
        sda = dm_a; sdb = dm_b;
        div_quotient = sda / sdb; div_remainder = sda % sdb;
      end else begin
        div_quotient = dm_a / dm_b; div_remainder = dm_a % dm_b;
      end
    end else if (stray_req != stray_ack) begin
      stray_ack     = stray_req;
      div_done      = 1'b1;
      div_quotient  = 32'hDEAD_BEEF;
      div_remainder = 32'hCAFE_F00D;
    end
  end

  // ---------------- helpers ----------------
  function automatic hilo_t sb_pop();
    if (sb_q.size() == 0) return '{hi: 32'hx, lo: 32'hx};
    return sb_q.pop_front();
  endfunction

  // Called at a falling edge; request is accepted on the following rising edge.
  task automatic issue(muldiv_op_t op, logic [31:0] a, logic [31:0] b);
    req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = MULT; src_a = '0; src_b = '0; flush = 1'b0;
    repeat (2) @(negedge clock);
    n_tests++;
    if ({busy, mul_valid, div_start, div_cancel, mul_signed, div_signed} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
        {busy, mul_valid, div_start, div_cancel, mul_signed, div_signed});
    end
    reset = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({mul_a, mul_b, div_dividend, div_divisor, hi_value, lo_value} !== 192'h0) begin
      n_fail++; $display("FAIL reset_data: hi=%h lo=%h mul_a=%h mul_b=%h want 0",
        hi_value, lo_value, mul_a, mul_b);
    end
  endtask

  task automatic run_mul(string name, muldiv_op_t op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] ehi, logic [31:0] elo);
    int busy_cnt = 0, mv_cnt = 0;
    sb_q.push_back('{hi: ehi, lo: elo});
    issue(op, a, b);
    n_tests++;
    if (mul_signed !== (op == MULT) || mul_a !== a || mul_b !== b) begin
      n_fail++; $display("FAIL %s_operands: signed=%b a=%h b=%h want %b %h %h",
        name, mul_signed, mul_a, mul_b, op == MULT, a, b);
    end
    for (int i = 0; i < 20 && busy; i++) begin
      busy_cnt++; mv_cnt += int'(mul_valid);
      @(negedge clock);
    end
    n_tests++;
    if (busy_cnt != MUL_L + 1 || mv_cnt != 1) begin
      n_fail++; $display("FAIL %s_timing: busy cycles=%0d mul_valid pulses=%0d want %0d 1",
        name, busy_cnt, mv_cnt, MUL_L + 1);
    end
    exp_v = sb_pop();
    n_tests++;
    if (hi_value !== exp_v.hi || lo_value !== exp_v.lo) begin
      n_fail++; $display("FAIL %s_hilo: got %h/%h want %h/%h",
        name, hi_value, lo_value, exp_v.hi, exp_v.lo);
    end
    m_hi = ehi; m_lo = elo;
  endtask

  task automatic test_mult();
    run_mul("mult", MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mul("multu", MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
  endtask

  task automatic run_div(string name, muldiv_op_t op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] ehi, logic [31:0] elo);
    int busy_cnt = 0, ds_cnt = 0;
    sb_q.push_back('{hi: ehi, lo: elo});
    issue(op, a, b);
    for (int i = 0; i < 60 && busy; i++) begin
      busy_cnt++; ds_cnt += int'(div_start);
      @(negedge clock);
    end
    n_tests++;
    if (busy_cnt != DIV_CYC + 1 || ds_cnt != 1) begin
      n_fail++; $display("FAIL %s_timing: busy cycles=%0d div_start pulses=%0d want %0d 1",
        name, busy_cnt, ds_cnt, DIV_CYC + 1);
    end
    exp_v = sb_pop();
    n_tests++;
    if (hi_value !== exp_v.hi || lo_value !== exp_v.lo) begin
      n_fail++; $display("FAIL %s_hilo: got %h/%h want %h/%h",
        name, hi_value, lo_value, exp_v.hi, exp_v.lo);
    end
    m_hi = ehi; m_lo = elo;
  endtask

  task automatic test_div();
    run_div("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_div("div_signed", DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
  endtask

  task automatic test_mthi_mtlo();
    sb_q.push_back('{hi: 32'h1234_5678, lo: m_lo});
    sb_q.push_back('{hi: 32'h1234_5678, lo: 32'h9ABC_DEF0});
    req_valid = 1'b1; req_op = MTHI; src_a = 32'h1234_5678; src_b = 32'h5555_5555;
    @(negedge clock);
    exp_v = sb_pop();
    n_tests++;
    if (hi_value !== exp_v.hi || lo_value !== exp_v.lo || busy !== 1'b0) begin
      n_fail++; $display("FAIL mthi: got %h/%h busy=%b want %h/%h busy=0",
        hi_value, lo_value, busy, exp_v.hi, exp_v.lo);
    end
    req_op = MTLO; src_a = 32'h9ABC_DEF0;
    @(negedge clock);
    req_valid = 1'b0;
    exp_v = sb_pop();
    n_tests++;
    if (hi_value !== exp_v.hi || lo_value !== exp_v.lo || busy !== 1'b0) begin
      n_fail++; $display("FAIL mtlo: got %h/%h busy=%b want %h/%h busy=0",
        hi_value, lo_value, busy, exp_v.hi, exp_v.lo);
    end
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
  endtask

  task automatic test_div_flush();
    issue(DIV, 32'd50, 32'd3);
    repeat (4) @(negedge clock);
    flush = 1'b1;
    #1;
    n_tests++;
    if (div_cancel !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL div_flush_cancel: div_cancel=%b busy=%b want 1 1", div_cancel, busy);
    end
    @(negedge clock);
    flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || div_cancel !== 1'b0 || hi_value !== m_hi || lo_value !== m_lo) begin
      n_fail++; $display("FAIL div_flush_idle: busy=%b cancel=%b hilo=%h/%h want 0 0 %h/%h",
        busy, div_cancel, hi_value, lo_value, m_hi, m_lo);
    end
    stray_req++;
    repeat (3) @(negedge clock);
    n_tests++;
    if (hi_value !== m_hi || lo_value !== m_lo || busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_div_done: hilo=%h/%h busy=%b want %h/%h 0",
        hi_value, lo_value, busy, m_hi, m_lo);
    end
  endtask

  task automatic test_mul_flush();
    issue(MULTU, 32'd3, 32'd5);
    repeat (MUL_L) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || hi_value !== m_hi || lo_value !== m_lo) begin
      n_fail++; $display("FAIL mul_flush_final: busy=%b hilo=%h/%h want 0 %h/%h",
        busy, hi_value, lo_value, m_hi, m_lo);
    end
    req_valid = 1'b1; req_op = MULT; src_a = 32'd7; src_b = 32'd9; flush = 1'b1;
    @(negedge clock);
    req_op = MTHI; src_a = 32'hAAAA_0000;
    n_tests++;
    if (mul_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop_mult: mul_valid=%b busy=%b want 0 0", mul_valid, busy);
    end
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    n_tests++;
    if (hi_value !== m_hi || busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop_mthi: hi=%h busy=%b want %h 0", hi_value, busy, m_hi);
    end
  endtask

  task automatic test_reset_mid_div();
    bit seen = 0;
    issue(DIVU, 32'd1000, 32'd9);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || hi_value !== 32'h0 || lo_value !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_div: busy=%b hilo=%h/%h want 0 0/0",
        busy, hi_value, lo_value);
    end
    @(negedge clock);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    sb_q.push_back('{hi: 32'h0, lo: 32'h0});
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      seen = div_done;
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL reset_div_done_timeout: div_done=0 want 1 within 40 cycles");
    end
    @(negedge clock);
    exp_v = sb_pop();
    n_tests++;
    if (hi_value !== exp_v.hi || lo_value !== exp_v.lo || busy !== 1'b0) begin
      n_fail++; $display("FAIL late_div_done: hilo=%h/%h busy=%b want %h/%h 0",
        hi_value, lo_value, busy, exp_v.hi, exp_v.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_div_flush();
    test_mul_flush();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Execute-stage front end for the multiply/divide datapath. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and launches the external pipelined multiplier or the iterative divider. Consumes their results, holds the architectural HI/LO registers, and drives the pipeline stall while an operation is in flight.

## Interface
- MUL_LATENCY, 2: cycles from `mul_valid` to a valid `mul_result`; 1..4.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  execute stage presents an operation.
- req_op  in  3  `muldiv_op_t`: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- src_a, src_b  in  CPU_DATA_WIDTH  rs, rt operands. MTHI/MTLO use `src_a` only.
- flush  in  1  exception/eret; cancels the in-flight operation.
- busy  out  1  stall request to the pipeline.
- hi_value, lo_value  out  CPU_DATA_WIDTH  architectural HI/LO, registered.
- mul_valid  out  1  one-cycle launch pulse to the multiplier.
- mul_signed  out  1  signed multiply.
- mul_a, mul_b  out  CPU_DATA_WIDTH  multiplier operands.
- mul_result  in  2*CPU_DATA_WIDTH  {hi, lo} product.
- div_start  out  1  one-cycle launch pulse to the divider.
- div_cancel  out  1  one-cycle abort pulse; the divider returns to WAITING_STATE.
- div_signed  out  1  signed divide.
- div_dividend, div_divisor  out  CPU_DATA_WIDTH  divider operands.
- div_done  in  1  one-cycle pulse; quotient/remainder valid.
- div_quotient, div_remainder  in  CPU_DATA_WIDTH  divider results.

## Operation
- A request is accepted when `req_valid && !busy && !flush`.
- State machine (`muldiv_state_t`) has three states: IDLE, MUL_WAIT, DIV_WAIT.
  - IDLE, accept MULT/MULTU: latch operands and signedness, go to MUL_WAIT, load the latency counter with MUL_LATENCY.
  - IDLE, accept DIV/DIVU: latch operands, go to DIV_WAIT.
  - IDLE, accept MTHI/MTLO: write `src_a` to HI/LO at that edge. State stays IDLE; `busy` does not assert.
  - MUL_WAIT: the counter decrements each cycle after launch. In the cycle it reads 0, HI <= `mul_result[63:32]`, LO <= `mul_result[31:0]`, then go to IDLE.
  - DIV_WAIT: on `div_done`, HI <= `div_remainder`, LO <= `div_quotient`, then go to IDLE.
- `busy` = (state != IDLE); it is a registered-state decode.
- `mul_valid`/`div_start` assert in the first cycle of MUL_WAIT/DIV_WAIT only. Operand outputs are driven from the latched registers and held constant through the wait.
- Divide by zero: no special case. HI/LO take whatever the divider returns.
- `flush` while in MUL_WAIT/DIV_WAIT: go to IDLE at the next edge with no HI/LO write. From DIV_WAIT, `div_cancel` pulses in the flush cycle.
- `flush` in the same cycle as `div_done` or the final MUL_WAIT cycle: flush wins, no write.
- `flush` with `req_valid` in IDLE: the request is dropped, including MTHI/MTLO.
- `div_done` or a late `mul_result` while IDLE: ignored.
- Reset, including mid-operation: state IDLE, HI = LO = 0, counter 0, all latched operands 0.

## Timing
- Reset values: `busy`, `mul_valid`, `div_start`, `div_cancel`, `mul_signed`, `div_signed` = 0. All operand outputs = 0. `hi_value` = `lo_value` = 0.
- Multiply, accepted in cycle T:
  - `mul_valid` = 1 in T+1.
  - `busy` = 1 in T+1 .. T+1+MUL_LATENCY.
  - HI/LO updated at the end of T+1+MUL_LATENCY.
  - The next request can be accepted in T+2+MUL_LATENCY.
- Divide, accepted in T:
  - `div_start` = 1 in T+1.
  - `busy` = 1 from T+1 through the `div_done` cycle D.
  - HI/LO are visible in D+1.
- MTHI/MTLO accepted in T: new value on `hi_value`/`lo_value` in T+1, zero stall.
- MFHI/MFLO read `hi_value`/`lo_value` directly. The pipeline stalls on `busy`; there is no bypass.

## Structure
- Add package `muldiv_params` beside `divider_params`. It holds:
  - `muldiv_op_t` (3-bit enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5).
  - `muldiv_state_t` (2-bit enum: IDLE=0, MUL_WAIT=1, DIV_WAIT=2).
  - It reuses `cpu_data_t` and `multiply_result_bus_t` from the existing packages.
- No sub-module: the FSM, counter and HI/LO registers stay in one module. The multiplier and divider are instantiated by the parent.

## Test plan
- Reset mid-DIV_WAIT: assert `reset` -> `busy` drops immediately, HI = LO = 0. A later `div_done` leaves HI/LO at 0.
- MULT, `src_a`=0xFFFFFFFF, `src_b`=0x00000002, signed, MUL_LATENCY=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. `busy` high for exactly 3 cycles.
- DIVU 100/7, divider model `div_done` 33 cycles after start -> LO=14, HI=2. `busy` spans start..done. `div_start` is a single pulse.
- MTHI 0x12345678 immediately followed by MTLO 0x9ABCDEF0 -> HI and LO updated on consecutive cycles, `busy` never high.
- DIV accepted, `flush` 5 cycles later -> `div_cancel` pulse in the flush cycle, state IDLE next cycle, HI/LO unchanged. A subsequent stray `div_done` is ignored.
- Final MUL_WAIT cycle coinciding with `flush` -> no HI/LO write. A `req_valid` MULT with `flush` in IDLE -> not accepted, `mul_valid` stays 0.
